// File: rtl/alu_pkg.sv
// Shared ALU definitions: aluctl encodings used by both the ALU control decoder
// and the execute unit, plus the execute-unit FSM states.
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0100;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NE  = 4'b1000;
   localparam logic [3:0] ALU_XOR = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_RESP  = 2'd2
   } alu_state_e;

   function automatic logic is_shift(input logic [3:0] ctl);
      return (ctl == ALU_SLL) || (ctl == ALU_SRL);
   endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle evaluator for every non-shift ALU op plus the illegal-code flag.
// Shift codes pass op A through, which is the correct answer for a zero shift amount.
module alu_comb_core
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [3:0]      aluctl_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] result_o,
   output logic            illegal_o
);

   always_comb begin
      result_o  = '0;
      illegal_o = 1'b0;
      case (aluctl_i)
         ALU_AND: result_o = a_i & b_i;
         ALU_OR:  result_o = a_i | b_i;
         ALU_ADD: result_o = a_i + b_i;
         ALU_SUB: result_o = a_i - b_i;
         ALU_XOR: result_o = a_i ^ b_i;
         ALU_SLT: result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         ALU_NE:  result_o = {{(XLEN-1){1'b0}}, (a_i != b_i)};
         ALU_SLL,
         ALU_SRL: result_o = a_i;
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: one-cycle ops via alu_comb_core, shifts via an iterative
// 1-bit-per-cycle shifter, valid/ready handshake on both sides.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      aluctl,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   alu_state_e         state_q, state_d;
   logic [XLEN-1:0]    res_q, res_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               dir_q, dir_d;
   logic               zero_q, zero_d;
   logic               ill_q, ill_d;

   logic [XLEN-1:0]    core_res;
   logic               core_ill;
   logic [SHAMT_W-1:0] shamt;
   logic               accept;
   logic               long_shift;
   logic [XLEN-1:0]    shifted;

   alu_comb_core #(.XLEN(XLEN)) u_core (
      .aluctl_i  (aluctl),
      .a_i       (op_a),
      .b_i       (op_b),
      .result_o  (core_res),
      .illegal_o (core_ill)
   );

   assign shamt      = op_b[SHAMT_W-1:0];
   assign accept     = in_valid && (state_q == ST_IDLE) && !flush;
   assign long_shift = is_shift(aluctl) && (shamt != '0);
   // res_q doubles as the shifter working register; dir_q = 1 means shift right
   assign shifted    = dir_q ? (res_q >> 1) : (res_q << 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         res_q   <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         zero_q  <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         zero_q  <= zero_d;
         ill_q   <= ill_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (accept) state_d = long_shift ? ST_SHIFT : ST_RESP;
            ST_SHIFT: if (cnt_q == SHAMT_W'(1)) state_d = ST_RESP;
            ST_RESP:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      res_d  = res_q;
      cnt_d  = cnt_q;
      dir_d  = dir_q;
      zero_d = zero_q;
      ill_d  = ill_q;
      if (flush) begin
         cnt_d = '0;
      end else if (state_q == ST_IDLE && accept) begin
         if (long_shift) begin
            res_d  = op_a;
            cnt_d  = shamt;
            dir_d  = (aluctl == ALU_SRL);
            zero_d = 1'b0;
            ill_d  = 1'b0;
         end else begin
            res_d  = core_res;
            zero_d = (core_res == '0);
            ill_d  = core_ill;
         end
      end else if (state_q == ST_SHIFT) begin
         res_d  = shifted;
         cnt_d  = cnt_q - SHAMT_W'(1);
         zero_d = (shifted == '0);
      end
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_RESP);
      result    = res_q;
      zero      = zero_q;
      illegal   = ill_q;
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table for single operations, plus
// hand-written sequences for backpressure, flush and reset during a response.
module tb_alu_exec_unit;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  aluctl;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   int n_checks = 0;
   int n_fail   = 0;

   alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .aluctl    (aluctl),
      .op_a      (op_a),
      .op_b      (op_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  ctl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zro;
      logic        ill;
      int          lat;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at 1 time unit after an edge; returns at 1 time unit after the edge
   // where out_valid was seen (or the bound expired).
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic issue(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1;
      aluctl   = ctl;
      op_a     = a;
      op_b     = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      aluctl   = 4'($urandom);
      op_a     = $urandom;
      op_b     = $urandom;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int lat;
      string tag;
      tag = $sformatf("vec%0d", idx);
      issue(v.ctl, v.a, v.b);
      wait_valid(lat);
      check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".latency"}, 32'(lat), 32'(v.lat));
      check({tag, ".result"}, result, v.res);
      check({tag, ".zero"}, 32'(zero), 32'(v.zro));
      check({tag, ".illegal"}, 32'(illegal), 32'(v.ill));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, ".idle_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, ".idle_out_valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int lat;
      vecs[0]  = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1};
      vecs[1]  = '{4'b0110, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1};
      vecs[2]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1};
      vecs[3]  = '{4'b1000, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b1, 1'b0, 1};
      vecs[4]  = '{4'b0011, 32'h0000_0001, 32'd31,        32'h8000_0000, 1'b0, 1'b0, 32};
      vecs[5]  = '{4'b0100, 32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1'b0, 5};
      vecs[6]  = '{4'b0011, 32'hDEAD_BEEF, 32'd32,        32'hDEAD_BEEF, 1'b0, 1'b0, 1};
      vecs[7]  = '{4'b1111, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b1, 1};
      vecs[8]  = '{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1};
      vecs[9]  = '{4'b0001, 32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 1'b0, 1'b0, 1};
      vecs[10] = '{4'b1100, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0, 1};
      vecs[11] = '{4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1};
      vecs[12] = '{4'b0100, 32'hFFFF_FFFF, 32'd31,        32'h0000_0001, 1'b0, 1'b0, 32};
      vecs[13] = '{4'b1000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 1'b0, 1'b0, 1};
      vecs[14] = '{4'b0101, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1};
      vecs[15] = '{4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1};
      vecs[16] = '{4'b0011, 32'h0000_0003, 32'hFFFF_FFE1, 32'h0000_0006, 1'b0, 1'b0, 2};

      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      aluctl    = 4'b0000;
      op_a      = '0;
      op_b      = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.in_ready", 32'(in_ready), 32'd1);
      check("rst.result", result, 32'd0);
      check("rst.zero", 32'(zero), 32'd0);
      check("rst.illegal", 32'(illegal), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

      // Backpressure: hold the response for 5 cycles.
      issue(4'b0010, 32'd2, 32'd3);
      wait_valid(lat);
      check("bp.latency", 32'(lat), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp.hold_valid", 32'(out_valid), 32'd1);
         check("bp.hold_result", result, 32'd5);
         check("bp.hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp.release_in_ready", 32'(in_ready), 32'd1);
      check("bp.release_valid", 32'(out_valid), 32'd0);

      // Flush during SLL by 10, with a competing request in the flush cycle.
      issue(4'b0011, 32'd1, 32'd10);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("fl.shift_in_ready", 32'(in_ready), 32'd0);
      check("fl.shift_valid", 32'(out_valid), 32'd0);
      flush = 1'b1;
      @(posedge clk); #1;
      check("fl.idle_in_ready", 32'(in_ready), 32'd1);
      check("fl.idle_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      aluctl   = 4'b0010;
      op_a     = 32'd7;
      op_b     = 32'd8;
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      check("fl.req_dropped_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         check("fl.no_valid", 32'(out_valid), 32'd0);
      end
      run_vec(100, '{4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1});

      // Reset while a response is pending.
      issue(4'b1100, 32'h0000_00FF, 32'h0000_0F00);
      wait_valid(lat);
      check("rr.valid", 32'(out_valid), 32'd1);
      check("rr.result", result, 32'h0000_0FFF);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rr.valid_after", 32'(out_valid), 32'd0);
      check("rr.result_after", result, 32'd0);
      check("rr.in_ready_after", 32'(in_ready), 32'd1);
      run_vec(101, '{4'b0100, 32'hF000_0000, 32'd28, 32'h0000_000F, 1'b0, 1'b0, 29});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU for the pipelined RV32 core. It consumes the 4-bit aluctl code produced by the ALU control decoder together with two operands, and returns a registered result, a zero flag and an illegal-code flag. Most operations complete in one cycle. Shifts use an iterative 1-bit-per-cycle shifter to save area, so the block uses a valid/ready handshake on both its input and output sides.

Parameters:
- XLEN, 32, operand and result width.
- SHAMT_W, 5, shift-amount width, log2(XLEN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; aborts any operation in flight
- in_valid  in  1  operation request valid
- in_ready  out  1  unit can accept a request
- aluctl  in  4  operation code from ALU control
- op_a  in  XLEN  operand A (rs1/PC)
- op_b  in  XLEN  operand B (rs2/imm); shift amount is op_b[SHAMT_W-1:0]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  XLEN  operation result
- zero  out  1  result == 0
- illegal  out  1  aluctl was not a defined code

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- aluctl codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SRL, 0110 SUB.
  - 0111 SLT: signed compare, result = {31'b0, a<b}.
  - 1000 NE: result = {31'b0, a!=b}.
  - 1100 XOR.
  - Any other code: result = 0, illegal = 1.
- Arithmetic: ADD and SUB wrap modulo 2^XLEN; no carry or overflow output. SRL is logical (zero fill).
- FSM states: IDLE, SHIFT, RESP.
  - IDLE: in_ready = 1. On in_valid:
    - Non-shift op, or shift with shamt = 0: latch the computed result and go to RESP. out_valid rises the next cycle (latency 1).
    - Shift with shamt > 0: load op_a into the working register and shamt into the counter, then go to SHIFT.
  - SHIFT: in_ready = 0. Each cycle, shift by 1 in the latched direction and decrement the counter. When the counter reaches 0 after its shift, go to RESP. out_valid is first high at accept + shamt + 1 cycles.
  - RESP: out_valid = 1, in_ready = 0. result, zero and illegal are held stable while out_ready = 0. On out_ready, go to IDLE. There is no same-cycle accept of a new request, so back-to-back throughput is one op per 2 cycles.
- zero and illegal are registered alongside result and are only meaningful while out_valid = 1.
- flush: highest priority after reset. In any state, the next state is IDLE and out_valid drops the next cycle. A request presented in the same cycle as flush is not accepted.
- Reset: out_valid = 0, in_ready = 1 after reset (state IDLE), result = 0, zero = 0, illegal = 0, counter = 0. Reset mid-SHIFT or mid-RESP discards the operation.
- Operands and aluctl are sampled only on the accept cycle; later changes have no effect.

Decomposition:
- Shared package alu_pkg:
  - aluctl localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SRL, ALU_SUB, ALU_SLT, ALU_NE, ALU_XOR).
  - FSM state encodings.
  - The same constants are to be referenced by the ALU control decoder.
- One sub-module, alu_comb_core: a purely combinational evaluator for all non-shift ops plus the illegal flag. The FSM, iterative shifter and handshake stay in alu_exec_unit.

Test Plan:
- ADD: a=0xFFFFFFFF, b=1, aluctl=0010 -> out_valid 1 cycle after accept, result=0, zero=1.
- SUB and SLT: SUB a=5, b=7 -> 0xFFFFFFFE. SLT a=0xFFFFFFFF(-1), b=1 -> result=1. NE a=b=0x1234 -> result=0, zero=1.
- SLL a=0x1, b=31 -> out_valid at accept+32, result=0x80000000. SRL a=0x80000000, b=4 -> 0x08000000 at accept+5. Shift with b=0 -> latency 1, result=a.
- Backpressure: hold out_ready=0 for 5 cycles in RESP -> result stable, in_ready=0. Raise out_ready -> IDLE next cycle, in_ready=1.
- Illegal aluctl=1111 -> result=0, illegal=1, zero=1.
- Flush at cycle 3 of an SLL by 10 -> IDLE next cycle, no out_valid. A new ADD 2+3 then returns 5. Reset asserted in RESP -> out_valid=0 and result=0 the next cycle.
